// File: rtl/fetch_sequencer.sv
// fetch_sequencer: steps one instruction at a time through fetch, decode,
// execute and advance, handing the program counter a start pulse on launch
// and an advance pulse (with branch information) after each retired
// instruction. Counts retired instructions with saturation.
module fetch_sequencer #(
  parameter int COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [8:0]         pc,
  input  logic               done,
  input  logic [8:0]         imem_data,
  input  logic               exec_ready,
  input  logic               cond_flag,
  output logic               pc_start,
  output logic [8:0]         imem_addr,
  output logic [8:0]         instr,
  output logic               instr_valid,
  output logic               nextIns,
  output logic               jumpFlag,
  output logic [7:0]         target,
  output logic               busy,
  output logic               prog_done,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_FETCH   = 3'd2,
    ST_DECODE  = 3'd3,
    ST_EXEC    = 3'd4,
    ST_ADVANCE = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};
  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  state_t               state_r;
  state_t               state_next_s;
  logic [8:0]           instr_r;
  logic                 instr_valid_r;
  logic [COUNT_W-1:0]   count_r;
  logic                 pc_start_r;
  logic                 busy_r;
  logic                 prog_done_r;
  logic                 next_ins_r;
  logic                 jump_s;
  logic [7:0]           target_s;

  // Branch decision: opcode 110 always jumps, 111 jumps on the condition.
  function automatic logic branch_taken(input logic [8:0] word, input logic cond);
    logic taken;
    case (word[8:6])
      3'b110:  taken = 1'b1;
      3'b111:  taken = cond;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  // State register; reset forces IDLE from any state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic for the fetch/execute loop.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_LAUNCH;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LAUNCH: state_next_s = ST_FETCH;
      ST_FETCH:  state_next_s = ST_DECODE;
      ST_DECODE: begin
        if (done) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (exec_ready) begin
          state_next_s = ST_ADVANCE;
        end else begin
          state_next_s = ST_EXEC;
        end
      end
      ST_ADVANCE: state_next_s = ST_FETCH;
      ST_DONE: begin
        if (start) begin
          state_next_s = ST_LAUNCH;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Instruction latch, valid flag and saturating retire counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      instr_r       <= 9'h000;
      instr_valid_r <= 1'b0;
      count_r       <= '0;
    end else begin
      case (state_r)
        ST_LAUNCH: begin
          count_r <= '0;
        end
        ST_DECODE: begin
          if (!done) begin
            instr_r       <= imem_data;
            instr_valid_r <= 1'b1;
          end
        end
        ST_ADVANCE: begin
          instr_valid_r <= 1'b0;
          if (count_r != COUNT_MAX) begin
            count_r <= count_r + COUNT_ONE;
          end
        end
        default: begin
          instr_r <= instr_r;
        end
      endcase
    end
  end

  // Status and pulse outputs registered from the upcoming state so they
  // line up exactly with the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_start_r  <= 1'b0;
      busy_r      <= 1'b0;
      prog_done_r <= 1'b0;
      next_ins_r  <= 1'b0;
    end else begin
      pc_start_r  <= (state_next_s == ST_LAUNCH);
      busy_r      <= (state_next_s != ST_IDLE) && (state_next_s != ST_DONE);
      prog_done_r <= (state_next_s == ST_DONE);
      next_ins_r  <= (state_next_s == ST_ADVANCE);
    end
  end

  // Branch outputs; the condition is sampled live during the advance cycle.
  always_comb begin
    jump_s   = 1'b0;
    target_s = 8'h00;
    if (next_ins_r && branch_taken(instr_r, cond_flag)) begin
      jump_s   = 1'b1;
      target_s = {2'b00, instr_r[5:0]};
    end else begin
      jump_s   = 1'b0;
      target_s = 8'h00;
    end
  end

  assign imem_addr   = pc;
  assign instr       = instr_r;
  assign instr_valid = instr_valid_r;
  assign instr_count = count_r;
  assign pc_start    = pc_start_r;
  assign busy        = busy_r;
  assign prog_done   = prog_done_r;
  assign nextIns     = next_ins_r;
  assign jumpFlag    = jump_s;
  assign target      = target_s;

endmodule
